// File: rtl/seq_timing_pkg.sv
// Shared constants and state encoding for the sequence/timing generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds default widths, the opcode field position within the instruction
// register, and the 2-bit controller state encoding (value 3 is illegal).
package seq_timing_pkg;

    localparam int SC_W_DEF  = 4;   // sequence counter width, T width = 2**SC_W
    localparam int OP_W_DEF  = 3;   // opcode field width, D width = 2**OP_W
    localparam int IR_W_DEF  = 16;  // instruction register width

    // Field positions for the default 16-bit instruction word
    localparam int I_BIT_IDX = 15;
    localparam int OP_MSB    = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/onehot_dec_team1.sv
// Binary to one-hot decoder with an enable that forces the output to zero.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   sel_i    [N-1:0]     binary select
//   en_i                 when low, onehot_o is all zero
//   onehot_o [2**N-1:0]  one-hot of sel_i when enabled
module onehot_dec_team1 #(
    parameter int N = 4
) (
    input  logic [N-1:0]      sel_i,
    input  logic              en_i,
    output logic [2**N-1:0]   onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_timing_team1.sv
// Timing (T) and opcode-decode (D) generator feeding per-register control logic.
// Latency: T/D are combinational from registered SC/opcode; decode captured at the T2 edge, D valid from T3.
// Backpressure: none; HLT parks the sequencer in HALT until START resumes it.
//
// Ports:
//   clk, RST_SC, CLR_GLOBAL  clock and two equivalent synchronous active-high resets
//   START, HLT, CLR_SC       sequencing controls (begin/resume, halt, end-of-instruction)
//   in_IR                    instruction register; I bit = MSB, opcode just below it
//   T, D, I_bit, out_SC      one-hot timing, one-hot opcode, latched I bit, counter value
//   RUN, ERR_SC              running status and sticky watchdog error
// Build option: define SC_WATCHDOG_EN to halt with a sticky ERR_SC when SC
// reaches its last value without a clear; otherwise SC wraps and ERR_SC is 0.
module seq_timing_team1
    import seq_timing_pkg::*;
#(
    parameter int SC_W = SC_W_DEF,
    parameter int OP_W = OP_W_DEF,
    parameter int IR_W = IR_W_DEF
) (
    input  logic                 clk,
    input  logic                 RST_SC,
    input  logic                 CLR_GLOBAL,
    input  logic                 START,
    input  logic                 HLT,
    input  logic                 CLR_SC,
    input  logic [IR_W-1:0]      in_IR,
    output logic [2**SC_W-1:0]   T,
    output logic [2**OP_W-1:0]   D,
    output logic                 I_bit,
    output logic [SC_W-1:0]      out_SC,
    output logic                 RUN,
    output logic                 ERR_SC
);

    state_e            state_q;
    logic [SC_W-1:0]   sc_q;
    logic [OP_W-1:0]   opcode_q;
    logic              d_valid_q;
    logic              i_bit_q;
    logic              rst;
    logic              decode_now;
    logic              wd_trip;

    // Low instruction bits (address/operand) are consumed by other logic.
    logic              unused_ir_bits;
    assign unused_ir_bits = ^in_IR[IR_W-OP_W-2:0];

    assign rst        = RST_SC | CLR_GLOBAL;
    assign decode_now = (state_q == ST_RUN) && (sc_q == SC_W'(2));

`ifdef SC_WATCHDOG_EN
    // Counter reached its last step with no clear: the instruction overran.
    assign wd_trip = (sc_q == '1);
`else
    assign wd_trip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sc_q      <= '0;
            opcode_q  <= '0;
            d_valid_q <= 1'b0;
            i_bit_q   <= 1'b0;
        end else begin
            // Capture happens at the T2 edge even if HLT/CLR_SC end the
            // instruction on that same edge.
            if (decode_now) begin
                opcode_q  <= in_IR[IR_W-2 -: OP_W];
                i_bit_q   <= in_IR[IR_W-1];
                d_valid_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_q <= ST_RUN;
                        sc_q    <= '0;
                    end
                end
                ST_RUN: begin
                    if (HLT) begin
                        state_q <= ST_HALT;
                        sc_q    <= '0;
                    end else if (CLR_SC) begin
                        sc_q    <= '0;
                    end else if (wd_trip) begin
                        state_q <= ST_HALT;
                        sc_q    <= '0;
                    end else begin
                        sc_q    <= sc_q + 1'b1;   // natural wrap at the top
                    end
                end
                ST_HALT: begin
                    if (START) begin
                        state_q <= ST_RUN;
                        sc_q    <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sc_q    <= '0;
                end
            endcase
        end
    end

`ifdef SC_WATCHDOG_EN
    logic err_q;

    // Sticky: only a reset clears it; resuming from HALT leaves it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == ST_RUN && !HLT && !CLR_SC && wd_trip) begin
            err_q <= 1'b1;
        end
    end

    assign ERR_SC = err_q;
`else
    assign ERR_SC = 1'b0;
`endif

    assign RUN    = (state_q == ST_RUN);
    assign out_SC = sc_q;
    assign I_bit  = i_bit_q;

    onehot_dec_team1 #(.N(SC_W)) u_t_dec (
        .sel_i    (sc_q),
        .en_i     (RUN),
        .onehot_o (T)
    );

    onehot_dec_team1 #(.N(OP_W)) u_d_dec (
        .sel_i    (opcode_q),
        .en_i     (d_valid_q),
        .onehot_o (D)
    );

endmodule

// File: tb/tb_seq_timing_team1.sv
// Self-checking bench for seq_timing_team1 with a behavioural reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_timing_team1;

`ifdef SC_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_sc, clr_global, start, hlt, clr_sc;
    logic [15:0] in_ir;
    logic [15:0] t;
    logic [7:0]  d;
    logic        i_bit;
    logic [3:0]  out_sc;
    logic        run, err_sc;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: mode 0=idle, 1=running, 2=halted
    int m_mode = 0;
    int m_sc   = 0;
    int m_op   = 0;
    bit m_dv   = 1'b0;
    bit m_ib   = 1'b0;
    bit m_err  = 1'b0;

    seq_timing_team1 dut (
        .clk        (clk),
        .RST_SC     (rst_sc),
        .CLR_GLOBAL (clr_global),
        .START      (start),
        .HLT        (hlt),
        .CLR_SC     (clr_sc),
        .in_IR      (in_ir),
        .T          (t),
        .D          (d),
        .I_bit      (i_bit),
        .out_SC     (out_sc),
        .RUN        (run),
        .ERR_SC     (err_sc)
    );

    always #5 clk = ~clk;

    wire [30:0] dut_vec = {t, d, i_bit, out_sc, run, err_sc};

    function automatic logic [30:0] exp_vec();
        logic [15:0] et;
        logic [7:0]  ed;
        logic        er;
        er = (m_mode == 1);
        et = er ? 16'(32'd1 << m_sc) : 16'h0;
        ed = m_dv ? 8'(32'd1 << m_op) : 8'h0;
        return {et, ed, m_ib, 4'(m_sc), er, m_err};
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        if (rst_sc || clr_global) begin
            m_mode = 0; m_sc = 0; m_op = 0; m_dv = 0; m_ib = 0; m_err = 0;
        end else begin
            case (m_mode)
                0, 2: if (start) begin m_mode = 1; m_sc = 0; end
                default: begin
                    if (m_sc == 2) begin
                        m_op = int'(in_ir[14:12]); m_ib = in_ir[15]; m_dv = 1;
                    end
                    if (hlt) begin
                        m_mode = 2; m_sc = 0;
                    end else if (clr_sc) begin
                        m_sc = 0;
                    end else if (WD && m_sc == 15) begin
                        m_mode = 2; m_sc = 0; m_err = 1;
                    end else begin
                        m_sc = (m_sc + 1) % 16;
                    end
                end
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_reset();
        rst_sc = 1'b1; start = 0; hlt = 0; clr_sc = 0; clr_global = 0;
        cyc();
        rst_sc = 1'b0;
    endtask

    task automatic test_reset();
        rst_sc = 1'b1; clr_global = 0; start = 0; hlt = 0; clr_sc = 0; in_ir = 16'h0;
        cyc(); cyc();
        rst_sc = 1'b0;
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
        end
        n_checks++;
        if (dut_vec !== 31'h0) begin
            n_fail++; $display("FAIL reset_zero: got %h expected 0", dut_vec);
        end
    endtask

    task automatic test_start_seq();
        pulse_reset();
        in_ir = 16'h0;
        start = 1'b1; cyc(); start = 1'b0;
        n_checks++;
        if (t !== 16'h0001 || run !== 1'b1) begin
            n_fail++; $display("FAIL start_t0: got T=%h RUN=%b expected T=0001 RUN=1", t, run);
        end
        cyc(); cyc();
        n_checks++;
        if (d !== 8'h00) begin
            n_fail++; $display("FAIL d_before_t3: got %h expected 00", d);
        end
        cyc();
        n_checks++;
        if (t !== 16'h0008 || d !== 8'h01) begin
            n_fail++; $display("FAIL start_t3: got T=%h D=%h expected T=0008 D=01", t, d);
        end
    endtask

    task automatic test_decode_clr_hlt();
        pulse_reset();
        in_ir = 16'hE123;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();                          // T2 cycle
        cyc();                                 // T3 cycle
        n_checks++;
        if (d !== 8'h40 || i_bit !== 1'b1) begin
            n_fail++; $display("FAIL decode_e123: got D=%h I=%b expected D=40 I=1", d, i_bit);
        end
        in_ir = 16'h1000;
        cyc(); cyc();                          // T5 cycle
        n_checks++;
        if (t !== 16'h0020) begin
            n_fail++; $display("FAIL reach_t5: got %h expected 0020", t);
        end
        clr_sc = 1'b1; cyc(); clr_sc = 1'b0;
        n_checks++;
        if (t !== 16'h0001 || out_sc !== 4'd0) begin
            n_fail++; $display("FAIL clr_sc: got T=%h SC=%0d expected T=0001 SC=0", t, out_sc);
        end
        cyc(); cyc();                          // T2 cycle of the next instruction
        n_checks++;
        if (d !== 8'h40 || i_bit !== 1'b1) begin
            n_fail++; $display("FAIL d_held: got D=%h I=%b expected D=40 I=1", d, i_bit);
        end
        cyc();                                 // T3
        n_checks++;
        if (d !== 8'h02 || i_bit !== 1'b0) begin
            n_fail++; $display("FAIL decode_1000: got D=%h I=%b expected D=02 I=0", d, i_bit);
        end
        cyc();                                 // T4
        hlt = 1'b1; clr_sc = 1'b1; cyc(); hlt = 1'b0; clr_sc = 1'b0;
        n_checks++;
        if (run !== 1'b0 || t !== 16'h0 || d !== 8'h02 || out_sc !== 4'd0) begin
            n_fail++; $display("FAIL hlt_clr: got RUN=%b T=%h D=%h SC=%0d expected 0 0000 02 0",
                               run, t, d, out_sc);
        end
        cyc();
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL halt_hold: got %h expected %h", dut_vec, exp_vec());
        end
        start = 1'b1; cyc(); start = 1'b0;
        n_checks++;
        if (t !== 16'h0001 || run !== 1'b1) begin
            n_fail++; $display("FAIL resume: got T=%h RUN=%b expected 0001 1", t, run);
        end
    endtask

    task automatic test_start_in_run();
        for (int i = 0; i < 7; i++) cyc();
        n_checks++;
        if (t !== 16'h0080) begin
            n_fail++; $display("FAIL reach_t7: got %h expected 0080", t);
        end
        start = 1'b1; cyc(); start = 1'b0;
        n_checks++;
        if (t !== 16'h0100) begin
            n_fail++; $display("FAIL start_in_run: got %h expected 0100", t);
        end
    endtask

    task automatic test_rst_mid();
        for (int k = 0; k < 2; k++) begin
            pulse_reset();
            in_ir = 16'h9000;                  // I=1, opcode 1
            start = 1'b1; cyc(); start = 1'b0;
            for (int i = 0; i < 6; i++) cyc();
            n_checks++;
            if (t !== 16'h0040 || d !== 8'h02 || i_bit !== 1'b1) begin
                n_fail++; $display("FAIL pre_rst_%0d: got T=%h D=%h I=%b expected 0040 02 1",
                                   k, t, d, i_bit);
            end
            if (k == 0) rst_sc = 1'b1; else clr_global = 1'b1;
            cyc();
            rst_sc = 1'b0; clr_global = 1'b0;
            n_checks++;
            if (t !== 16'h0 || d !== 8'h0 || i_bit !== 1'b0 || run !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_%0d: got T=%h D=%h I=%b RUN=%b expected all 0",
                                   k, t, d, i_bit, run);
            end
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        in_ir = 16'($urandom);
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 1; i < 16; i++) begin
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL wrap_step_%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (t !== 16'h8000) begin
            n_fail++; $display("FAIL reach_t15: got %h expected 8000", t);
        end
        cyc();
        if (WD) begin
            n_checks++;
            if (run !== 1'b0 || err_sc !== 1'b1 || t !== 16'h0) begin
                n_fail++; $display("FAIL wd_trip: got RUN=%b ERR=%b T=%h expected 0 1 0000",
                                   run, err_sc, t);
            end
            start = 1'b1; cyc(); start = 1'b0;
            n_checks++;
            if (run !== 1'b1 || err_sc !== 1'b1 || t !== 16'h0001) begin
                n_fail++; $display("FAIL wd_sticky: got RUN=%b ERR=%b T=%h expected 1 1 0001",
                                   run, err_sc, t);
            end
            pulse_reset();
            n_checks++;
            if (err_sc !== 1'b0) begin
                n_fail++; $display("FAIL wd_clear: got %b expected 0", err_sc);
            end
        end else begin
            n_checks++;
            if (t !== 16'h0001 || err_sc !== 1'b0 || run !== 1'b1) begin
                n_fail++; $display("FAIL wrap: got T=%h ERR=%b RUN=%b expected 0001 0 1",
                                   t, err_sc, run);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst_sc     = ($urandom_range(0, 99) == 0);
            clr_global = ($urandom_range(0, 99) == 0);
            start      = ($urandom_range(0, 3) == 0);
            hlt        = ($urandom_range(0, 19) == 0);
            clr_sc     = ($urandom_range(0, 9) == 0);
            in_ir      = 16'($urandom);
            cyc();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        rst_sc = 0; clr_global = 0; start = 0; hlt = 0; clr_sc = 0;
    endtask

    initial begin
        rst_sc = 1'b1; clr_global = 0; start = 0; hlt = 0; clr_sc = 0; in_ir = 16'h0;
        test_reset();
        test_start_seq();
        test_decode_clr_hlt();
        test_start_in_run();
        test_rst_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
